// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control for a 5-stage pipeline: ID-stage forwarding selects
// registered into EX, load-use and MDU-busy stall detection, and IF/ID/EX stall/flush generation.
module hazard_forward_unit #(
  parameter int MD_LATENCY = 4,
  parameter int MD_CNT_W   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_hilo_access,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic       ex_md_start,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic       branch_taken,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       md_busy
);

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY);
  localparam logic [MD_CNT_W-1:0] MD_ZERO = {MD_CNT_W{1'b0}};
  localparam logic [MD_CNT_W-1:0] MD_ONE  = {{(MD_CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]          fwd_a_s;
  logic [1:0]          fwd_b_s;
  logic                load_use_s;
  logic                md_stall_s;
  logic                stall_s;
  logic [MD_CNT_W-1:0] md_cnt_r;

  // A producer matches when it writes a nonzero register equal to the source.
  function automatic logic producer_hit(input logic wr, input logic [4:0] rd, input logic [4:0] src);
    return wr && (rd != 5'd0) && (rd == src);
  endfunction

  // The EX producer is younger than the MEM producer, so it takes priority.
  function automatic logic [1:0] fwd_select(
    input logic       used,
    input logic [4:0] src,
    input logic [4:0] e_rd,
    input logic       e_wr,
    input logic [4:0] m_rd,
    input logic       m_wr
  );
    logic [1:0] sel;
    if (!used) begin
      sel = FWD_RF;
    end else if (producer_hit(e_wr, e_rd, src)) begin
      sel = FWD_EXMEM;
    end else if (producer_hit(m_wr, m_rd, src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Forwarding decision for both operands of the instruction currently in ID.
  always_comb begin
    fwd_a_s = fwd_select(id_uses_rs, id_rs, ex_rd, ex_reg_write, mem_rd, mem_reg_write);
    fwd_b_s = fwd_select(id_uses_rt, id_rt, ex_rd, ex_reg_write, mem_rd, mem_reg_write);
  end

  // Load in EX whose result is needed by ID cannot be forwarded in time.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_mem_read) begin
      load_use_s = (id_uses_rs && producer_hit(ex_reg_write, ex_rd, id_rs)) ||
                   (id_uses_rt && producer_hit(ex_reg_write, ex_rd, id_rt));
    end else begin
      load_use_s = 1'b0;
    end
  end

  assign md_busy    = (md_cnt_r != MD_ZERO);
  assign md_stall_s = md_busy && id_hilo_access;

  // Stall/flush generation; a taken branch discards ID anyway, so it cancels any stall.
  always_comb begin
    stall_s  = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else begin
      stall_s  = (load_use_s || md_stall_s) && !branch_taken;
      stall_if = stall_s;
      stall_id = stall_s;
      flush_id = branch_taken;
      flush_ex = branch_taken || stall_s;
    end
  end

  // Forwarding selects advance with ID/EX; a bubble carries the regfile select.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (flush_ex) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= fwd_a_s;
      fwd_b <= fwd_b_s;
    end
  end

  // MDU busy counter; a new start reloads even while a previous op is counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_r <= MD_ZERO;
    end else if (ex_md_start) begin
      md_cnt_r <= MD_LOAD;
    end else if (md_cnt_r != MD_ZERO) begin
      md_cnt_r <= md_cnt_r - MD_ONE;
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios plus randomized
// stimulus against a rule-level reference model.
module tb_hazard_forward_unit;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rs, id_uses_rt, id_hilo_access;
  logic       ex_reg_write, ex_mem_read, ex_md_start, mem_reg_write, branch_taken;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_if, stall_id, flush_id, flush_ex, md_busy;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: registered selects and the MDU busy window by edge number.
  logic [1:0] m_fwd_a = 2'b00;
  logic [1:0] m_fwd_b = 2'b00;
  int         edge_cnt = 0;
  int         md_end   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.MD_LATENCY(LAT), .MD_CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_hilo_access(id_hilo_access),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_md_start(ex_md_start),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .branch_taken(branch_taken),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .md_busy(md_busy)
  );

  function automatic logic reads(input logic used, input logic [4:0] src,
                                 input logic [4:0] rd, input logic wr);
    return used && wr && (rd != 5'd0) && (rd == src);
  endfunction

  function automatic logic [1:0] pick(input logic used, input logic [4:0] src);
    if (reads(used, src, ex_rd, ex_reg_write)) return 2'b01;
    if (reads(used, src, mem_rd, mem_reg_write)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_busy();
    return edge_cnt < md_end;
  endfunction

  function automatic logic m_stall();
    logic lu;
    lu = ex_mem_read && (reads(id_uses_rs, id_rs, ex_rd, ex_reg_write) ||
                         reads(id_uses_rt, id_rt, ex_rd, ex_reg_write));
    return !rst && !branch_taken && (lu || (m_busy() && id_hilo_access));
  endfunction

  function automatic logic m_flush_ex();
    return !rst && (branch_taken || m_stall());
  endfunction

  function automatic logic [8:0] m_vec();
    logic s;
    s = m_stall();
    return {m_fwd_a, m_fwd_b, s, s, !rst && branch_taken, m_flush_ex(), m_busy()};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {fwd_a, fwd_b, stall_if, stall_id, flush_id, flush_ex, md_busy};
  endfunction

  task automatic idle();
    rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_hilo_access = 1'b0; ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    ex_md_start = 1'b0; mem_rd = 5'd0; mem_reg_write = 1'b0; branch_taken = 1'b0;
  endtask

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic tick();
    logic [1:0] na, nb;
    logic r, s;
    r = rst;
    s = ex_md_start;
    if (r || m_flush_ex()) begin
      na = 2'b00; nb = 2'b00;
    end else begin
      na = pick(id_uses_rs, id_rs);
      nb = pick(id_uses_rt, id_rt);
    end
    @(posedge clk);
    edge_cnt++;
    if (r) md_end = 0;
    else if (s) md_end = edge_cnt + LAT;
    m_fwd_a = na;
    m_fwd_b = nb;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; ex_md_start = 1'b1; branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
    #1;
    n_total++;
    if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {stall_if, stall_id, flush_id, flush_ex});
    else n_pass++;
    tick();
    tick();
    n_total++;
    if ({fwd_a, fwd_b, md_busy} !== 5'b00000)
      $display("FAIL reset_regs: got %b expected 00000", {fwd_a, fwd_b, md_busy});
    else n_pass++;
    idle();
    #1;
    n_total++;
    if ({md_busy, stall_if, flush_ex} !== 3'b000)
      $display("FAIL reset_release: got %b expected 000", {md_busy, stall_if, flush_ex});
    else n_pass++;
  endtask

  task automatic test_forward();
    idle();
    id_rs = 5'd5; id_uses_rs = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1;
    mem_rd = 5'd5; mem_reg_write = 1'b1;
    id_rt = 5'd7; id_uses_rt = 1'b0;
    tick();
    n_total++;
    if (fwd_a !== 2'b01) $display("FAIL fwd_exmem: got %b expected 01", fwd_a);
    else n_pass++;
    n_total++;
    if (fwd_b !== 2'b00) $display("FAIL fwd_unused: got %b expected 00", fwd_b);
    else n_pass++;
    ex_rd = 5'd0;
    tick();
    n_total++;
    if (fwd_a !== 2'b10) $display("FAIL fwd_memwb: got %b expected 10", fwd_a);
    else n_pass++;
    mem_rd = 5'd0;
    tick();
    n_total++;
    if (fwd_a !== 2'b00) $display("FAIL fwd_r0: got %b expected 00", fwd_a);
    else n_pass++;
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
    #1;
    n_total++;
    if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b1101)
      $display("FAIL load_use_stall: got %b expected 1101", {stall_if, stall_id, flush_id, flush_ex});
    else n_pass++;
    tick();
    n_total++;
    if (fwd_b !== 2'b00) $display("FAIL load_use_bubble: got %b expected 00", fwd_b);
    else n_pass++;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0; mem_rd = 5'd8; mem_reg_write = 1'b1;
    #1;
    n_total++;
    if ({stall_if, stall_id, flush_ex} !== 3'b000)
      $display("FAIL load_use_release: got %b expected 000", {stall_if, stall_id, flush_ex});
    else n_pass++;
    tick();
    n_total++;
    if (fwd_b !== 2'b10) $display("FAIL load_use_fwd: got %b expected 10", fwd_b);
    else n_pass++;
  endtask

  task automatic test_mdu();
    idle();
    ex_md_start = 1'b1;
    tick();
    ex_md_start = 1'b0; id_hilo_access = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      #1;
      n_total++;
      if ({md_busy, stall_if, stall_id, flush_ex} !== 4'b1111)
        $display("FAIL mdu_busy_%0d: got %b expected 1111", i, {md_busy, stall_if, stall_id, flush_ex});
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if ({md_busy, stall_if, flush_ex} !== 3'b000)
      $display("FAIL mdu_done: got %b expected 000", {md_busy, stall_if, flush_ex});
    else n_pass++;
  endtask

  task automatic test_branch();
    idle();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1;
    branch_taken = 1'b1;
    #1;
    n_total++;
    if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0011)
      $display("FAIL branch_prio: got %b expected 0011", {stall_if, stall_id, flush_id, flush_ex});
    else n_pass++;
    tick();
    n_total++;
    if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL branch_bubble: got %b expected 0000", {fwd_a, fwd_b});
    else n_pass++;
  endtask

  task automatic test_reset_mid_mdu();
    idle();
    ex_md_start = 1'b1;
    tick();
    ex_md_start = 1'b0; id_hilo_access = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_total++;
    if ({md_busy, stall_if, flush_ex} !== 3'b100)
      $display("FAIL mid_mdu_rst_hold: got %b expected 100", {md_busy, stall_if, flush_ex});
    else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++;
    if ({md_busy, stall_if, stall_id, flush_ex} !== 4'b0000)
      $display("FAIL mid_mdu_rst: got %b expected 0000", {md_busy, stall_if, stall_id, flush_ex});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 49) == 0);
      id_rs          = 5'($urandom_range(0, 3));
      id_rt          = 5'($urandom_range(0, 3));
      id_uses_rs     = 1'($urandom_range(0, 1));
      id_uses_rt     = 1'($urandom_range(0, 1));
      id_hilo_access = 1'($urandom_range(0, 1));
      ex_rd          = 5'($urandom_range(0, 3));
      ex_reg_write   = 1'($urandom_range(0, 1));
      ex_mem_read    = 1'($urandom_range(0, 1));
      ex_md_start    = ($urandom_range(0, 9) == 0);
      mem_rd         = 5'($urandom_range(0, 3));
      mem_reg_write  = 1'($urandom_range(0, 1));
      branch_taken   = ($urandom_range(0, 7) == 0);
      #1;
      n_total++;
      if (dut_vec() !== m_vec())
        $display("FAIL random_%0d: got %b expected %b", i, dut_vec(), m_vec());
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_forward();
    test_load_use();
    test_mdu();
    test_branch();
    test_reset_mid_mdu();
    test_random();
    idle();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
